reg_dst_sel_pipe: RTL
=====================

Name: reg_dst_sel_pipe

Overview:
- Parametrised successor to the link-register destination mux.
- Selects the register-file write destination from one of four sources per instruction: rt, rd, the link register, or no write.
- Carries the result through a small in-order buffer with a valid/ready handshake.
- Sits between decode and write-back, so the link override works in a pipelined datapath under back-pressure.

Parameters:
- REG_ADDR_W, 5, width of a register index.
- LINK_REG, 31, index forced when the link mode is selected; must fit in REG_ADDR_W.
- DEPTH, 2, number of buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  upstream holds a valid request.
- in_ready  out  1  buffer can accept a request this cycle.
- rt  in  REG_ADDR_W  rt field.
- rd  in  REG_ADDR_W  rd field.
- dst_mode  in  2  0 = rt, 1 = rd, 2 = LINK_REG, 3 = no write.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream accepts the head entry.
- dest  out  REG_ADDR_W  destination index of the head entry.
- wr_en  out  1  head entry writes the register file.

Behaviour:
- Push occurs when in_valid and in_ready are both high. Pop occurs when out_valid and out_ready are both high.
- On push, the selected index and wr_en are computed combinationally from rt, rd and dst_mode, then stored in the tail entry:
  - mode 0: dest = rt, wr_en = 1.
  - mode 1: dest = rd, wr_en = 1.
  - mode 2: dest = LINK_REG, wr_en = 1.
  - mode 3: dest = 0, wr_en = 0.
- Storage is a circular buffer with wr_ptr, rd_ptr and count, where count is clog2(DEPTH+1) bits. Pointers wrap from DEPTH-1 to 0.
- in_ready = (count != DEPTH). It depends on state only, never on in_valid or out_ready.
- out_valid = (count != 0).
- dest and wr_en always reflect the entry at rd_ptr. When out_valid = 0, they are driven to 0.
- Latency is 1 cycle: a request pushed at edge N appears at the outputs after edge N; there is no combinational bypass.
- Ordering is strict FIFO.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - Legal at any count where in_ready = 1.
- Full (count = DEPTH): in_ready = 0, in_valid is ignored, and a pop in the same cycle does not enable a push that cycle.
- Empty (count = 0): out_ready is ignored and no pop occurs.
- Flush:
  - On the next edge, count and both pointers are cleared to 0.
  - Takes precedence over a push or pop in the same cycle; the concurrent request is dropped.
  - Upstream sees in_ready = 1 on the following cycle.
- Reset:
  - Takes precedence over flush.
  - Clears count, wr_ptr and rd_ptr; buffer contents are don't-care.
  - After the reset edge: in_ready = 1, out_valid = 0, dest = 0, wr_en = 0.
  - Reset asserted mid-stream drops all entries, including the head being presented.
- The head's dest and wr_en are stable while out_valid = 1 and out_ready = 0.

Optional Feature:
- Macro: REG_DST_ZERO_SQUASH_EN.
- Defined: any push whose selected dest is 0 is stored with wr_en = 0. This covers mode 0 or 1 with a zero index, and mode 2 if LINK_REG = 0. Writes to $zero never leave the block.
- Not defined: wr_en is 1 for modes 0-2 regardless of index; $zero is protected downstream.
- Ports, latency and handshake are identical in both builds.

Test Plan:
- Reset then idle: reset high 2 cycles, then low -> in_ready = 1, out_valid = 0, dest = 0, wr_en = 0.
- Mode select, out_ready held 1:
  - push rt = 8, rd = 17 with mode 0, 1, 2, 3 on consecutive cycles -> dest = 8, 17, 31, 0 with wr_en = 1, 1, 1, 0, one cycle after each push.
- Back-pressure with DEPTH = 2 and out_ready = 0:
  - push mode 1 rd = 5, then mode 1 rd = 6 -> in_ready = 0 and a third push (rd = 7) is ignored; head holds dest = 5.
  - raise out_ready -> outputs 5 then 6; rd = 7 never appears.
- Simultaneous push/pop at count = 1 -> count stays 1; outputs follow push order across a pointer wrap over 6 transfers (rd = 1..6 out in order).
- Flush vs push, with two entries buffered and flush asserted together with in_valid for mode 2 -> next cycle out_valid = 0 and in_ready = 1; the link request is absent.
- Zero squash, mode 0 with rt = 0 -> dest = 0 with wr_en = 0 when REG_DST_ZERO_SQUASH_EN is defined, wr_en = 1 when it is not.

Source files
------------

// File: rtl/reg_dst_sel_pipe.sv
// Register-file write-destination selector (rt / rd / link / none) feeding an in-order valid/ready buffer.
// Optional build macro REG_DST_ZERO_SQUASH_EN: pushes that select register 0 are stored with wr_en = 0.
module reg_dst_sel_pipe #(
    parameter int REG_ADDR_W = 5,
    parameter int LINK_REG   = 31,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [1:0]            dst_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] dest,
    output logic                  wr_en
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Handshake: a transfer happens on an edge where valid and ready are both high.
    // in_ready/out_valid depend only on the occupancy count, never on the partner's signal.

    logic [REG_ADDR_W-1:0] dest_mem_q [DEPTH];
    logic                  wr_en_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic                  push;
    logic                  pop;
    logic                  mem_we;
    logic [REG_ADDR_W-1:0] sel_dest;
    logic                  sel_we;

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign mem_we    = push & ~flush & ~reset;

    always_comb begin
        sel_dest = '0;
        sel_we   = 1'b0;
        case (dst_mode)
            2'd0: begin
                sel_dest = rt;
                sel_we   = 1'b1;
            end
            2'd1: begin
                sel_dest = rd;
                sel_we   = 1'b1;
            end
            2'd2: begin
                sel_dest = REG_ADDR_W'(LINK_REG);
                sel_we   = 1'b1;
            end
            default: begin
                sel_dest = '0;
                sel_we   = 1'b0;
            end
        endcase
`ifdef REG_DST_ZERO_SQUASH_EN
        // $zero is never written, so the write is killed before it is buffered.
        if (sel_dest == '0) begin
            sel_we = 1'b0;
        end
`endif
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            dest_mem_q[wr_ptr_q]  <= sel_dest;
            wr_en_mem_q[wr_ptr_q] <= sel_we;
        end
    end

    assign dest  = out_valid ? dest_mem_q[rd_ptr_q] : '0;
    assign wr_en = out_valid ? wr_en_mem_q[rd_ptr_q] : 1'b0;

endmodule
